// File: rtl/z80_ld_extaddr_a_seq.sv
// Execution sequencer for LD (nn),A (opcode 0x32): fetches the little-endian
// operand, stores A at nn and retires with a z80fi trace record.
//
// state    | meaning
// IDLE     | waiting for start from the decoder
// FETCH_LO | read operand low byte at pc+1
// FETCH_HI | read operand high byte at pc+2
// WRITE    | store latched A at nn
// RETIRE   | one-cycle done / z80fi_valid pulse

module z80_ld_extaddr_a_seq (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] pc_in,
  input  logic [7:0]  reg_a,
  output logic        busy,
  output logic        bus_req,
  output logic        bus_wr,
  output logic [15:0] bus_addr,
  output logic [7:0]  bus_wdata,
  input  logic [7:0]  bus_rdata,
  input  logic        bus_ack,
  output logic [15:0] pc_out,
  output logic [15:0] memptr_out,
  output logic        done,
  output logic        z80fi_valid,
  output logic [31:0] z80fi_insn,
  output logic [3:0]  z80fi_insn_len,
  output logic [15:0] z80fi_pc_rdata,
  output logic [15:0] z80fi_pc_wdata,
  output logic        z80fi_mem_wr,
  output logic [15:0] z80fi_mem_waddr,
  output logic [7:0]  z80fi_mem_wdata,
  output logic        z80fi_mem_rd
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH_LO,
    FETCH_HI,
    WRITE,
    RETIRE
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [15:0] pc_q;
  logic [7:0]  a_q;
  logic [7:0]  nn_lo;
  logic [7:0]  nn_hi;
  logic [15:0] nn;
  logic [15:0] nn_inc;
  logic        bus_done;
  logic        req_nxt;
  logic        ld_start;
  logic        ld_lo;
  logic        ld_hi;
  logic        ld_retire;

  assign nn       = {nn_hi, nn_lo};
  assign nn_inc   = nn + 16'd1;
  // an ack with no request pending is not a completed bus cycle
  assign bus_done = bus_req && bus_ack;

  always_comb begin
    state_nxt = state;
    req_nxt   = 1'b0;
    ld_start  = 1'b0;
    ld_lo     = 1'b0;
    ld_hi     = 1'b0;
    ld_retire = 1'b0;
    busy      = 1'b1;
    bus_wr    = 1'b0;
    bus_addr  = 16'h0000;
    bus_wdata = 8'h00;
    done      = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          state_nxt = FETCH_LO;
          req_nxt   = 1'b1;
          ld_start  = 1'b1;
        end
      end
      FETCH_LO: begin
        bus_addr = pc_q + 16'd1;
        req_nxt  = !bus_done;
        if (bus_done) begin
          ld_lo     = 1'b1;
          state_nxt = FETCH_HI;
        end
      end
      FETCH_HI: begin
        bus_addr = pc_q + 16'd2;
        req_nxt  = !bus_done;
        if (bus_done) begin
          ld_hi     = 1'b1;
          state_nxt = WRITE;
        end
      end
      WRITE: begin
        bus_wr    = 1'b1;
        bus_addr  = nn;
        bus_wdata = a_q;
        req_nxt   = !bus_done;
        if (bus_done) begin
          ld_retire = 1'b1;
          state_nxt = RETIRE;
        end
      end
      RETIRE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      bus_req         <= 1'b0;
      pc_q            <= 16'h0000;
      a_q             <= 8'h00;
      nn_lo           <= 8'h00;
      nn_hi           <= 8'h00;
      pc_out          <= 16'h0000;
      memptr_out      <= 16'h0000;
      z80fi_insn      <= 32'h0000_0000;
      z80fi_insn_len  <= 4'd0;
      z80fi_pc_rdata  <= 16'h0000;
      z80fi_mem_wr    <= 1'b0;
      z80fi_mem_waddr <= 16'h0000;
      z80fi_mem_wdata <= 8'h00;
    end else begin
      state   <= state_nxt;
      bus_req <= req_nxt;
      if (ld_start) begin
        pc_q <= pc_in;
        a_q  <= reg_a;
      end
      if (ld_lo) nn_lo <= bus_rdata;
      if (ld_hi) nn_hi <= bus_rdata;
      // trace payload is captured on the write ack and held until the next retirement
      if (ld_retire) begin
        pc_out          <= pc_q + 16'd3;
        memptr_out      <= {a_q, nn_inc[7:0]};
        z80fi_insn      <= {8'h00, nn_hi, nn_lo, 8'h32};
        z80fi_insn_len  <= 4'd3;
        z80fi_pc_rdata  <= pc_q;
        z80fi_mem_wr    <= 1'b1;
        z80fi_mem_waddr <= nn;
        z80fi_mem_wdata <= a_q;
      end
    end
  end

  assign z80fi_valid    = done;
  assign z80fi_pc_wdata = pc_out;
  assign z80fi_mem_rd   = 1'b0;

endmodule

// File: tb/tb_z80_ld_extaddr_a_seq.sv
// Directed bench for z80_ld_extaddr_a_seq: a wait-state bus slave with a small
// memory, a retirement monitor, and hand-computed expected values per vector.
`timescale 1ns/1ps

module tb_z80_ld_extaddr_a_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] pc_in;
  logic [7:0]  reg_a;
  logic        busy;
  logic        bus_req;
  logic        bus_wr;
  logic [15:0] bus_addr;
  logic [7:0]  bus_wdata;
  logic [7:0]  bus_rdata;
  logic        bus_ack;
  logic [15:0] pc_out;
  logic [15:0] memptr_out;
  logic        done;
  logic        z80fi_valid;
  logic [31:0] z80fi_insn;
  logic [3:0]  z80fi_insn_len;
  logic [15:0] z80fi_pc_rdata;
  logic [15:0] z80fi_pc_wdata;
  logic        z80fi_mem_wr;
  logic [15:0] z80fi_mem_waddr;
  logic [7:0]  z80fi_mem_wdata;
  logic        z80fi_mem_rd;

  z80_ld_extaddr_a_seq dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .pc_in           (pc_in),
    .reg_a           (reg_a),
    .busy            (busy),
    .bus_req         (bus_req),
    .bus_wr          (bus_wr),
    .bus_addr        (bus_addr),
    .bus_wdata       (bus_wdata),
    .bus_rdata       (bus_rdata),
    .bus_ack         (bus_ack),
    .pc_out          (pc_out),
    .memptr_out      (memptr_out),
    .done            (done),
    .z80fi_valid     (z80fi_valid),
    .z80fi_insn      (z80fi_insn),
    .z80fi_insn_len  (z80fi_insn_len),
    .z80fi_pc_rdata  (z80fi_pc_rdata),
    .z80fi_pc_wdata  (z80fi_pc_wdata),
    .z80fi_mem_wr    (z80fi_mem_wr),
    .z80fi_mem_waddr (z80fi_mem_waddr),
    .z80fi_mem_wdata (z80fi_mem_wdata),
    .z80fi_mem_rd    (z80fi_mem_rd)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0]  mem [0:65535];
  int          n_checks = 0;
  int          n_pass = 0;
  int          waits = 0;
  logic        hold_wr = 1'b0;
  int          since = 0;
  logic [15:0] rd_q [$];
  int          wr_cnt = 0;
  logic [15:0] wr_addr = 16'h0;
  logic [7:0]  wr_data = 8'h0;
  int          done_cnt = 0;
  int          done_cyc = 0;
  int          t_start = 0;
  int          w_start = 0;
  logic        cap_valid;
  logic [15:0] cap_pc_out, cap_memptr, cap_pc_rdata, cap_pc_wdata, cap_waddr;
  logic [31:0] cap_insn;
  logic [3:0]  cap_len;
  logic        cap_mem_wr, cap_mem_rd;
  logic [7:0]  cap_wdata;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  // Bus slave: acks a request once waits+2 cycles have elapsed since the
  // accepted start or the previous ack; writes can be held off with hold_wr.
  initial begin : bus_slave
    logic        in_wait;
    logic [15:0] s_addr;
    logic        s_wr;
    logic [7:0]  s_wdata;
    in_wait   = 1'b0;
    s_addr    = 16'h0;
    s_wr      = 1'b0;
    s_wdata   = 8'h0;
    bus_ack   = 1'b0;
    bus_rdata = 8'h00;
    forever begin
      @(posedge clk); #2;
      bus_ack = 1'b0;
      since++;
      if (bus_req) begin
        if (in_wait) begin
          check_eq("wait_addr",  {16'h0, bus_addr},  {16'h0, s_addr});
          check_eq("wait_wr",    {31'h0, bus_wr},    {31'h0, s_wr});
          check_eq("wait_wdata", {24'h0, bus_wdata}, {24'h0, s_wdata});
        end
        if (!(bus_wr && hold_wr) && since >= waits + 2) begin
          bus_ack = 1'b1;
          in_wait = 1'b0;
          since   = 0;
          if (bus_wr) begin
            wr_cnt++;
            wr_addr = bus_addr;
            wr_data = bus_wdata;
          end else begin
            bus_rdata = mem[bus_addr];
            rd_q.push_back(bus_addr);
          end
        end else begin
          in_wait = 1'b1;
          s_addr  = bus_addr;
          s_wr    = bus_wr;
          s_wdata = bus_wdata;
        end
      end else begin
        in_wait = 1'b0;
      end
      if (start && !busy && !reset) since = 0;
    end
  end

  initial begin : done_mon
    forever begin
      @(posedge clk); #3;
      if (done) begin
        done_cnt++;
        done_cyc     = cyc;
        cap_valid    = z80fi_valid;
        cap_pc_out   = pc_out;
        cap_memptr   = memptr_out;
        cap_insn     = z80fi_insn;
        cap_len      = z80fi_insn_len;
        cap_pc_rdata = z80fi_pc_rdata;
        cap_pc_wdata = z80fi_pc_wdata;
        cap_mem_wr   = z80fi_mem_wr;
        cap_waddr    = z80fi_mem_waddr;
        cap_wdata    = z80fi_mem_wdata;
        cap_mem_rd   = z80fi_mem_rd;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic wait_done(input int d0, input int budget);
    int k = 0;
    while (done_cnt == d0 && k < budget) begin
      @(posedge clk); #4;
      k++;
    end
    check_eq("done_seen", done_cnt - d0, 1);
  endtask

  task automatic run_insn(input logic [15:0] pc, input logic [7:0] a);
    int d0;
    @(posedge clk); #1;
    pc_in   = pc;
    reg_a   = a;
    start   = 1'b1;
    t_start = cyc;
    w_start = wr_cnt;
    d0      = done_cnt;
    rd_q.delete();
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(d0, 80);
  endtask

  task automatic check_insn(input string name, input int exp_lat,
                            input logic [15:0] rd0, input logic [15:0] rd1,
                            input logic [15:0] waddr, input logic [7:0] wdata,
                            input logic [15:0] exp_pc_out, input logic [15:0] exp_memptr,
                            input logic [31:0] exp_insn, input logic [15:0] exp_pc_rd);
    check_eq({name, ".latency"}, done_cyc - t_start, exp_lat);
    check_eq({name, ".n_reads"}, rd_q.size(), 2);
    if (rd_q.size() == 2) begin
      check_eq({name, ".rd0"}, {16'h0, rd_q[0]}, {16'h0, rd0});
      check_eq({name, ".rd1"}, {16'h0, rd_q[1]}, {16'h0, rd1});
    end
    check_eq({name, ".n_writes"},   wr_cnt - w_start, 1);
    check_eq({name, ".wr_addr"},    {16'h0, wr_addr}, {16'h0, waddr});
    check_eq({name, ".wr_data"},    {24'h0, wr_data}, {24'h0, wdata});
    check_eq({name, ".valid"},      {31'h0, cap_valid}, 32'd1);
    check_eq({name, ".pc_out"},     {16'h0, cap_pc_out}, {16'h0, exp_pc_out});
    check_eq({name, ".pc_wdata"},   {16'h0, cap_pc_wdata}, {16'h0, exp_pc_out});
    check_eq({name, ".memptr"},     {16'h0, cap_memptr}, {16'h0, exp_memptr});
    check_eq({name, ".insn"},       cap_insn, exp_insn);
    check_eq({name, ".insn_len"},   {28'h0, cap_len}, 32'd3);
    check_eq({name, ".pc_rdata"},   {16'h0, cap_pc_rdata}, {16'h0, exp_pc_rd});
    check_eq({name, ".mem_wr"},     {31'h0, cap_mem_wr}, 32'd1);
    check_eq({name, ".mem_waddr"},  {16'h0, cap_waddr}, {16'h0, waddr});
    check_eq({name, ".mem_wdata"},  {24'h0, cap_wdata}, {24'h0, wdata});
    check_eq({name, ".mem_rd"},     {31'h0, cap_mem_rd}, 32'd0);
  endtask

  initial begin : main
    int d0;
    int w0;
    int k;
    int first_done;
    reset = 1'b1;
    start = 1'b0;
    pc_in = 16'h0000;
    reg_a = 8'h00;

    // reset state
    repeat (3) @(posedge clk);
    #3;
    check_eq("rst.busy",     {31'h0, busy}, 32'd0);
    check_eq("rst.bus_req",  {31'h0, bus_req}, 32'd0);
    check_eq("rst.bus_addr", {16'h0, bus_addr}, 32'd0);
    check_eq("rst.done",     {31'h0, done}, 32'd0);
    check_eq("rst.pc_out",   {16'h0, pc_out}, 32'd0);
    check_eq("rst.memptr",   {16'h0, memptr_out}, 32'd0);
    check_eq("rst.insn",     z80fi_insn, 32'd0);
    check_eq("rst.len",      {28'h0, z80fi_insn_len}, 32'd0);
    check_eq("rst.mem_wr",   {31'h0, z80fi_mem_wr}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // basic store, zero waits
    mem[16'h1001] = 8'h34;
    mem[16'h1002] = 8'h12;
    run_insn(16'h1000, 8'h5A);
    check_insn("basic", 7, 16'h1001, 16'h1002, 16'h1234, 8'h5A,
               16'h1003, 16'h5A35, 32'h0012_3432, 16'h1000);

    // three wait states on every bus cycle
    waits = 3;
    run_insn(16'h1000, 8'h5A);
    check_insn("waits3", 16, 16'h1001, 16'h1002, 16'h1234, 8'h5A,
               16'h1003, 16'h5A35, 32'h0012_3432, 16'h1000);
    waits = 0;

    // address wrap at the top of memory
    mem[16'hFFFF] = 8'hFF;
    mem[16'h0000] = 8'hFF;
    run_insn(16'hFFFE, 8'h01);
    check_insn("wrap", 7, 16'hFFFF, 16'h0000, 16'hFFFF, 8'h01,
               16'h0001, 16'h0100, 32'h00FF_FF32, 16'hFFFE);

    // stray starts in FETCH_HI and RETIRE, reg_a changed mid-sequence
    mem[16'h2001] = 8'hCD;
    mem[16'h2002] = 8'hAB;
    @(posedge clk); #1;
    pc_in   = 16'h2000;
    reg_a   = 8'h77;
    start   = 1'b1;
    t_start = cyc;
    w_start = wr_cnt;
    d0      = done_cnt;
    rd_q.delete();
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (i == 2) reg_a = 8'h11;
      if (i == 3 || i == 7) begin
        start = 1'b1;
        pc_in = 16'h5555;
      end
    end
    #3;
    check_eq("stray.n_done", done_cnt - d0, 1);
    check_insn("stray", 7, 16'h2001, 16'h2002, 16'hABCD, 8'h77,
               16'h2003, 16'h77CE, 32'h00AB_CD32, 16'h2000);
    check_eq("stray.idle_busy", {31'h0, busy}, 32'd0);

    // reset while the write is pending
    mem[16'h3001] = 8'h78;
    mem[16'h3002] = 8'h56;
    hold_wr = 1'b1;
    @(posedge clk); #1;
    pc_in = 16'h3000;
    reg_a = 8'h99;
    start = 1'b1;
    d0    = done_cnt;
    w0    = wr_cnt;
    @(posedge clk); #1;
    start = 1'b0;
    k = 0;
    while (!(bus_req && bus_wr) && k < 40) begin
      @(posedge clk); #1;
      k++;
    end
    check_eq("rstw.pending", {31'h0, (bus_req && bus_wr)}, 32'd1);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    #2;
    check_eq("rstw.bus_req", {31'h0, bus_req}, 32'd0);
    check_eq("rstw.busy",    {31'h0, busy}, 32'd0);
    check_eq("rstw.done",    {31'h0, done}, 32'd0);
    check_eq("rstw.valid",   {31'h0, z80fi_valid}, 32'd0);
    check_eq("rstw.insn",    z80fi_insn, 32'd0);
    check_eq("rstw.pc_out",  {16'h0, pc_out}, 32'd0);
    check_eq("rstw.mem_wr",  {31'h0, z80fi_mem_wr}, 32'd0);
    check_eq("rstw.waddr",   {16'h0, z80fi_mem_waddr}, 32'd0);
    repeat (6) @(posedge clk);
    #3;
    check_eq("rstw.no_done",  done_cnt - d0, 0);
    check_eq("rstw.no_write", wr_cnt - w0, 0);
    hold_wr = 1'b0;

    // reset together with start: reset wins
    @(posedge clk); #1;
    reset = 1'b1;
    start = 1'b1;
    pc_in = 16'h7000;
    @(posedge clk); #1;
    reset = 1'b0;
    start = 1'b0;
    #2;
    check_eq("rsts.busy",    {31'h0, busy}, 32'd0);
    check_eq("rsts.bus_req", {31'h0, bus_req}, 32'd0);

    // normal run after the aborted write
    run_insn(16'h3000, 8'h99);
    check_insn("after_rst", 7, 16'h3001, 16'h3002, 16'h5678, 8'h99,
               16'h3003, 16'h9979, 32'h0056_7832, 16'h3000);

    // back-to-back: second start in the cycle after done
    mem[16'h4001] = 8'h10;
    mem[16'h4002] = 8'h20;
    mem[16'h6001] = 8'hFF;
    mem[16'h6002] = 8'h7F;
    run_insn(16'h4000, 8'hA1);
    check_insn("b2b_1", 7, 16'h4001, 16'h4002, 16'h2010, 8'hA1,
               16'h4003, 16'hA111, 32'h0020_1032, 16'h4000);
    first_done = done_cyc;
    run_insn(16'h6000, 8'hB2);
    check_eq("b2b.gap", done_cyc - first_done, 8);
    check_insn("b2b_2", 7, 16'h6001, 16'h6002, 16'h7FFF, 8'hB2,
               16'h6003, 16'hB200, 32'h007F_FF32, 16'h6000);

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
